// File: rtl/vector_result_streamer.sv
// Serialises one captured vector-unit result set (elements, dot product or reduction)
// into a valid/ready beat stream with index, kind and last markers.
module vector_result_streamer #(
   parameter int WIDTH  = 32,
   parameter int LENGTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                in_op,
   input  logic [WIDTH-1:0]          in_vector [0:LENGTH-1],
   input  logic [2*WIDTH-1:0]        in_dot,
   input  logic [WIDTH-1:0]          in_reduction,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*WIDTH-1:0]        out_data,
   output logic [$clog2(LENGTH)-1:0] out_index,
   output logic                      out_kind,
   output logic                      out_last,
   output logic                      op_err
);

   localparam int                IDX_W    = $clog2(LENGTH);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LENGTH - 1);
   localparam logic [2:0]        OP_DOT   = 3'b101;
   localparam logic [2:0]        OP_BAD   = 3'b111;
   localparam logic [2:0]        OP_VMAX  = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_VEC, S_SCAL} state_e;

   state_e               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     vec_q [0:LENGTH-1];
   logic [WIDTH-1:0]     vec_d [0:LENGTH-1];
   logic [2*WIDTH-1:0]   dot_q, dot_d;
   logic [WIDTH-1:0]     red_q, red_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 op_err_q, op_err_d;

   // NOTE: the capture array is reset along with the control state, so a set
   // aborted by reset leaves no stale payload behind; this costs reset fan-out only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         dot_q    <= '0;
         red_q    <= '0;
         idx_q    <= '0;
         op_err_q <= 1'b0;
         for (int i = 0; i < LENGTH; i++) vec_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q  <= state_d;
         op_q     <= op_d;
         vec_q    <= vec_d;
         dot_q    <= dot_d;
         red_q    <= red_d;
         idx_q    <= idx_d;
         op_err_q <= op_err_d;
      end
   end

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      vec_d    = vec_q;
      dot_d    = dot_q;
      red_d    = red_q;
      idx_d    = idx_q;
      op_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_op == OP_BAD) begin
                  op_err_d = 1'b1;
               end else begin
                  op_d    = in_op;
                  vec_d   = in_vector;
                  dot_d   = in_dot;
                  red_d   = in_reduction;
                  idx_d   = '0;
                  state_d = (in_op <= OP_VMAX) ? S_VEC : S_SCAL;
               end
            end
         end
         S_VEC: begin
            if (out_ready) begin
               // Index stops at the last element; the set closes instead of wrapping.
               if (idx_q == IDX_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_SCAL: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Beat fields derive purely from registered state, so they hold while stalled.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q != S_IDLE);
      out_index = idx_q;
      out_kind  = (state_q == S_SCAL);
      out_last  = 1'b0;
      out_data  = '0;
      op_err    = op_err_q;
      case (state_q)
         S_VEC: begin
            out_data = {{WIDTH{vec_q[idx_q][WIDTH-1]}}, vec_q[idx_q]};
            out_last = (idx_q == IDX_LAST);
         end
         S_SCAL: begin
            out_data = (op_q == OP_DOT) ? dot_q : {{WIDTH{red_q[WIDTH-1]}}, red_q};
            out_last = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vector_result_streamer.sv
// Randomised bench for vector_result_streamer: a queue-based reference model predicts
// every beat of each set, and a per-cycle monitor checks order, content and stall hold.
module tb_vector_result_streamer;

   localparam int WIDTH  = 32;
   localparam int LENGTH = 16;
   localparam int IW     = $clog2(LENGTH);

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [2:0]          in_op = '0;
   logic [WIDTH-1:0]    in_vector [0:LENGTH-1];
   logic [2*WIDTH-1:0]  in_dot = '0;
   logic [WIDTH-1:0]    in_reduction = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [2*WIDTH-1:0]  out_data;
   logic [IW-1:0]       out_index;
   logic                out_kind;
   logic                out_last;
   logic                op_err;

   typedef struct {
      logic [63:0] data;
      int          index;
      bit          kind;
      bit          last;
   } beat_t;

   beat_t exp_q [$];
   int    n_checks = 0;
   int    n_pass   = 0;

   vector_result_streamer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_vector(in_vector), .in_dot(in_dot), .in_reduction(in_reduction),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_kind(out_kind), .out_last(out_last),
      .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] sext(input logic [WIDTH-1:0] v);
      return 64'($signed(v));
   endfunction

   // Reference model: the beats a set must produce, straight from the opcode rules.
   task automatic model_set(input logic [2:0] op);
      beat_t b;
      if (op <= 3'd4) begin
         for (int i = 0; i < LENGTH; i++) begin
            b.data = sext(in_vector[i]); b.index = i; b.kind = 1'b0; b.last = (i == LENGTH - 1);
            exp_q.push_back(b);
         end
      end else if (op == 3'd5) begin
         b.data = in_dot; b.index = 0; b.kind = 1'b1; b.last = 1'b1;
         exp_q.push_back(b);
      end else if (op == 3'd6) begin
         b.data = sext(in_reduction); b.index = 0; b.kind = 1'b1; b.last = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   task automatic scramble_inputs();
      in_op = 3'($urandom);
      in_dot = {$urandom, $urandom};
      in_reduction = $urandom;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
   endtask

   // Present the currently driven set for one edge, then scramble in_* to prove snapshotting.
   task automatic capture_set();
      @(negedge clk);
      check("in_ready_before_capture", in_ready, 1'b1);
      model_set(in_op);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble_inputs();
   endtask

   // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random. stop_after < 0 runs to completion.
   task automatic run_stream(input int mode, input int stop_after);
      int    cyc = 0;
      int    pops = 0;
      bit    stalled = 1'b0;
      bit    r;
      beat_t held;
      beat_t e;
      while (exp_q.size() > 0 && cyc < 400 && (stop_after < 0 || pops < stop_after)) begin
         @(negedge clk);
         check("out_valid_streaming", out_valid, 1'b1);
         if (stalled) begin
            check("hold_data", out_data, held.data);
            check("hold_index", 64'(out_index), 64'(held.index));
            check("hold_kind", out_kind, held.kind);
            check("hold_last", out_last, held.last);
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         if (out_valid && r) begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_index", 64'(out_index), 64'(e.index));
            check("beat_kind", out_kind, e.kind);
            check("beat_last", out_last, e.last);
            check("in_ready_busy", in_ready, 1'b0);
            pops++;
            stalled = 1'b0;
         end else begin
            held.data = out_data; held.index = int'(out_index);
            held.kind = out_kind; held.last = out_last;
            stalled = 1'b1;
         end
         cyc++;
      end
      if (stop_after < 0) begin
         check("stream_timeout_remaining", 64'(exp_q.size()), 64'd0);
         @(negedge clk);
         check("in_ready_after_set", in_ready, 1'b1);
         check("out_valid_after_set", out_valid, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < LENGTH; i++) in_vector[i] = '0;

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_op_err", op_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Elements 1..16, always ready
      in_op = 3'b000;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = WIDTH'(i + 1);
      capture_set();
      run_stream(0, -1);

      // Negative element sign extension
      in_op = 3'b010;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
      in_vector[3] = 32'hFFFF_FFFB;
      capture_set();
      run_stream(0, -1);

      // Dot product and reduction scalar beats
      in_op = 3'b101;
      in_dot = 64'h0000_0001_0000_0000;
      capture_set();
      run_stream(0, -1);
      in_op = 3'b110;
      in_reduction = 32'hFFFF_FFFF;
      capture_set();
      run_stream(0, -1);

      // Stall pattern 1,0,0,1
      in_op = 3'b000;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
      capture_set();
      run_stream(1, -1);

      // Illegal opcode: one-cycle op_err, no beat
      @(negedge clk);
      in_op = 3'b111;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("op_err_pulse", op_err, 1'b1);
      check("op_err_no_valid", out_valid, 1'b0);
      check("op_err_in_ready", in_ready, 1'b1);
      @(negedge clk);
      check("op_err_cleared", op_err, 1'b0);
      check("op_err_still_no_valid", out_valid, 1'b0);

      // Reset mid-stream after beat 7
      in_op = 3'b001;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
      capture_set();
      run_stream(0, 8);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_last", out_last, 1'b0);
      check("midrst_out_data", out_data, 64'd0);
      check("midrst_out_index", 64'(out_index), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_idle", out_valid, 1'b0);
      in_op = 3'b000;
      for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
      capture_set();
      run_stream(0, -1);

      // Random sets with random back-pressure
      for (int s = 0; s < 12; s++) begin
         in_op = 3'($urandom_range(0, 6));
         in_dot = {$urandom, $urandom};
         in_reduction = $urandom;
         for (int i = 0; i < LENGTH; i++) in_vector[i] = $urandom;
         capture_set();
         run_stream(2, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
